// File: rtl/clint_bram_arbiter.sv
// Two-requester round-robin arbiter with beat locking in front of the CLINT's 32-bit BRAM port.
// Optional lock watchdog is enabled by defining CLINT_ARB_TIMEOUT_EN.
module clint_bram_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_addr,
    input  logic [3:0]  req0_we,
    input  logic [31:0] req0_wdata,
    input  logic        req0_lock,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_addr,
    input  logic [3:0]  req1_we,
    input  logic [31:0] req1_wdata,
    input  logic        req1_lock,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,

    output logic [15:0] bram_addr,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_wrdata,
    input  logic [31:0] bram_rddata,

    output logic        lock_timeout
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t state_q, state_d;
    logic        owner_q, owner_d;
    logic        rr_q, rr_d;

    logic        grant_any;
    logic        grant_id;
    logic        grant_lock;
    logic        timeout_fire;

    logic [READ_LATENCY-1:0] pipe_v;
    logic [READ_LATENCY-1:0] pipe_id;
    logic [READ_LATENCY-1:0] pipe_rd;
    logic                    rsp_v;
    logic                    rsp_id;
    logic                    rsp_rd;

    // Grant selection; reset suppresses every grant so all issue-side outputs read 0.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (!rst) begin
            if (state_q == LOCKED) begin
                grant_any = owner_q ? req1_valid : req0_valid;
                grant_id  = owner_q;
            end else if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_id  = rr_q;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign grant_lock = grant_id ? req1_lock : req0_lock;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        if (grant_any) begin
            if (grant_lock) begin
                state_d = LOCKED;
                owner_d = grant_id;
            end else begin
                state_d = UNLOCKED;
                rr_d    = ~grant_id;
            end
        end else if (timeout_fire) begin
            state_d = UNLOCKED;
            rr_d    = ~owner_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UNLOCKED;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

`ifdef CLINT_ARB_TIMEOUT_EN
    logic [7:0] idle_q;

    // Fires on the idle cycle that brings the count to LOCK_TIMEOUT, so the release lands next cycle.
    assign timeout_fire = (state_q == LOCKED) && !grant_any &&
                          (idle_q == 8'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= 8'd0;
        end else if (grant_any || (state_q != LOCKED) || timeout_fire) begin
            idle_q <= 8'd0;
        end else begin
            idle_q <= idle_q + 8'd1;
        end
    end
`else
    logic unused_lock_timeout_cfg;

    assign timeout_fire            = 1'b0;
    assign unused_lock_timeout_cfg = ^LOCK_TIMEOUT;
`endif

    assign lock_timeout = timeout_fire;

    assign req0_ready = grant_any && !grant_id;
    assign req1_ready = grant_any && grant_id;
    assign bram_en    = grant_any;

    always_comb begin
        bram_addr   = 16'd0;
        bram_we     = 4'd0;
        bram_wrdata = 32'd0;
        if (grant_any) begin
            if (grant_id) begin
                bram_addr   = req1_addr;
                bram_we     = req1_we;
                bram_wrdata = req1_wdata;
            end else begin
                bram_addr   = req0_addr;
                bram_we     = req0_we;
                bram_wrdata = req0_wdata;
            end
        end
    end

    // Response tracker: one entry per issued beat, aligned with the BRAM's fixed read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v  <= '0;
            pipe_id <= '0;
            pipe_rd <= '0;
        end else begin
            pipe_v[0]  <= grant_any;
            pipe_id[0] <= grant_id;
            pipe_rd[0] <= grant_any && (bram_we == 4'd0);
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_id[i] <= pipe_id[i-1];
                pipe_rd[i] <= pipe_rd[i-1];
            end
        end
    end

    assign rsp_v  = pipe_v[READ_LATENCY-1];
    assign rsp_id = pipe_id[READ_LATENCY-1];
    assign rsp_rd = pipe_rd[READ_LATENCY-1];

    assign rsp0_valid = rsp_v && !rsp_id;
    assign rsp1_valid = rsp_v && rsp_id;
    assign rsp0_rdata = (rsp0_valid && rsp_rd) ? bram_rddata : 32'd0;
    assign rsp1_rdata = (rsp1_valid && rsp_rd) ? bram_rddata : 32'd0;

endmodule

// File: tb/tb_clint_bram_arbiter.sv
// Bench for clint_bram_arbiter: instances with read latency 1 and 3 share stimulus and are
// compared every cycle against a rule-level model; the lock watchdog test follows CLINT_ARB_TIMEOUT_EN.
module tb_clint_bram_arbiter;

    localparam int LT = 4;

    typedef struct packed {
        logic        v;
        logic        lock;
        logic [15:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct packed {
        logic v;
        logic id;
        logic rd;
    } hist_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req0_valid = 1'b0, req0_lock = 1'b0;
    logic [15:0] req0_addr = 16'd0;
    logic [3:0]  req0_we = 4'd0;
    logic [31:0] req0_wdata = 32'd0;
    logic        req1_valid = 1'b0, req1_lock = 1'b0;
    logic [15:0] req1_addr = 16'd0;
    logic [3:0]  req1_we = 4'd0;
    logic [31:0] req1_wdata = 32'd0;
    logic [31:0] bram_rddata = 32'd0;

    logic        req0_ready [2];
    logic        req1_ready [2];
    logic        rsp0_valid [2];
    logic        rsp1_valid [2];
    logic [31:0] rsp0_rdata [2];
    logic [31:0] rsp1_rdata [2];
    logic [15:0] bram_addr [2];
    logic        bram_en [2];
    logic [3:0]  bram_we [2];
    logic [31:0] bram_wrdata [2];
    logic        lock_timeout [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        clint_bram_arbiter #(
            .READ_LATENCY((k == 0) ? 1 : 3),
            .LOCK_TIMEOUT(LT)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .req0_valid  (req0_valid),
            .req0_ready  (req0_ready[k]),
            .req0_addr   (req0_addr),
            .req0_we     (req0_we),
            .req0_wdata  (req0_wdata),
            .req0_lock   (req0_lock),
            .rsp0_valid  (rsp0_valid[k]),
            .rsp0_rdata  (rsp0_rdata[k]),
            .req1_valid  (req1_valid),
            .req1_ready  (req1_ready[k]),
            .req1_addr   (req1_addr),
            .req1_we     (req1_we),
            .req1_wdata  (req1_wdata),
            .req1_lock   (req1_lock),
            .rsp1_valid  (rsp1_valid[k]),
            .rsp1_rdata  (rsp1_rdata[k]),
            .bram_addr   (bram_addr[k]),
            .bram_en     (bram_en[k]),
            .bram_we     (bram_we[k]),
            .bram_wrdata (bram_wrdata[k]),
            .bram_rddata (bram_rddata),
            .lock_timeout(lock_timeout[k])
        );
    end

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    int    m_rr = 0;
    int    m_locked = 0;
    int    m_owner = 0;
    int    m_idle = 0;
    int    cyc = 0;
    hist_t hist [16];

    logic        s_ready0 [2];
    logic        s_ready1 [2];
    logic        s_en [2];
    logic        s_rsp0v [2];
    logic        s_rsp1v [2];
    logic        s_to [2];
    logic [31:0] s_rsp0d [2];
    logic [31:0] s_rsp1d [2];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic beat_t idleBeat();
        return '0;
    endfunction

    function automatic beat_t rdBeat(input logic [15:0] a, input logic lk);
        beat_t b;
        b = '0;
        b.v = 1'b1; b.lock = lk; b.addr = a;
        return b;
    endfunction

    function automatic beat_t wrBeat(input logic [15:0] a, input logic [3:0] we, input logic [31:0] d,
                                     input logic lk);
        beat_t b;
        b.v = 1'b1; b.lock = lk; b.addr = a; b.we = we; b.wdata = d;
        return b;
    endfunction

    function automatic beat_t rndBeat();
        beat_t b;
        b.v     = ($urandom_range(0, 3) != 0);
        b.lock  = ($urandom_range(0, 3) == 0);
        b.addr  = 16'($urandom);
        b.we    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
        b.wdata = $urandom;
        return b;
    endfunction

    // One clock cycle: drive, compare both instances against the model mid-cycle, advance the model.
    task automatic applyStimulus(input beat_t b0, input beat_t b1, input logic [31:0] rd);
        int          g;
        int          lat;
        logic        tfire;
        logic        glock;
        logic [15:0] e_addr;
        logic [3:0]  e_we;
        logic [31:0] e_wd;
        logic        e_r0v, e_r1v;
        logic [31:0] e_r0d, e_r1d;
        hist_t       h;

        req0_valid = b0.v; req0_lock = b0.lock; req0_addr = b0.addr; req0_we = b0.we; req0_wdata = b0.wdata;
        req1_valid = b1.v; req1_lock = b1.lock; req1_addr = b1.addr; req1_we = b1.we; req1_wdata = b1.wdata;
        bram_rddata = rd;
        @(negedge clk);

        g = -1;
        tfire = 1'b0;
        if (!rst) begin
            if (m_locked == 0) begin
                if (b0.v && b1.v) g = m_rr;
                else if (b0.v) g = 0;
                else if (b1.v) g = 1;
            end else if ((m_owner == 0) ? b0.v : b1.v) begin
                g = m_owner;
            end
`ifdef CLINT_ARB_TIMEOUT_EN
            if ((m_locked != 0) && (g < 0) && (m_idle + 1 == LT)) tfire = 1'b1;
`endif
        end
        e_addr = (g == 0) ? b0.addr : (g == 1) ? b1.addr : 16'd0;
        e_we   = (g == 0) ? b0.we : (g == 1) ? b1.we : 4'd0;
        e_wd   = (g == 0) ? b0.wdata : (g == 1) ? b1.wdata : 32'd0;
        glock  = (g == 0) ? b0.lock : (g == 1) ? b1.lock : 1'b0;

        for (int k = 0; k < 2; k++) begin
            lat   = (k == 0) ? 1 : 3;
            h     = hist[(cyc + 16 - lat) % 16];
            e_r0v = !rst && h.v && !h.id;
            e_r1v = !rst && h.v && h.id;
            e_r0d = (e_r0v && h.rd) ? rd : 32'd0;
            e_r1d = (e_r1v && h.rd) ? rd : 32'd0;
            checkOutput($sformatf("c%0d_L%0d_req0_ready", cyc, lat), 32'(req0_ready[k]), 32'(g == 0));
            checkOutput($sformatf("c%0d_L%0d_req1_ready", cyc, lat), 32'(req1_ready[k]), 32'(g == 1));
            checkOutput($sformatf("c%0d_L%0d_bram_en", cyc, lat), 32'(bram_en[k]), 32'(g >= 0));
            checkOutput($sformatf("c%0d_L%0d_bram_addr", cyc, lat), 32'(bram_addr[k]), 32'(e_addr));
            checkOutput($sformatf("c%0d_L%0d_bram_we", cyc, lat), 32'(bram_we[k]), 32'(e_we));
            checkOutput($sformatf("c%0d_L%0d_bram_wrdata", cyc, lat), bram_wrdata[k], e_wd);
            checkOutput($sformatf("c%0d_L%0d_rsp0_valid", cyc, lat), 32'(rsp0_valid[k]), 32'(e_r0v));
            checkOutput($sformatf("c%0d_L%0d_rsp0_rdata", cyc, lat), rsp0_rdata[k], e_r0d);
            checkOutput($sformatf("c%0d_L%0d_rsp1_valid", cyc, lat), 32'(rsp1_valid[k]), 32'(e_r1v));
            checkOutput($sformatf("c%0d_L%0d_rsp1_rdata", cyc, lat), rsp1_rdata[k], e_r1d);
            checkOutput($sformatf("c%0d_L%0d_lock_timeout", cyc, lat), 32'(lock_timeout[k]), 32'(tfire));
            s_ready0[k] = req0_ready[k];
            s_ready1[k] = req1_ready[k];
            s_en[k]     = bram_en[k];
            s_rsp0v[k]  = rsp0_valid[k];
            s_rsp1v[k]  = rsp1_valid[k];
            s_rsp0d[k]  = rsp0_rdata[k];
            s_rsp1d[k]  = rsp1_rdata[k];
            s_to[k]     = lock_timeout[k];
        end

        @(posedge clk);
        h.v  = (g >= 0);
        h.id = (g == 1);
        h.rd = (g >= 0) && (e_we == 4'd0);
        hist[cyc % 16] = h;
        cyc++;
        if (rst) begin
            m_locked = 0; m_rr = 0; m_idle = 0;
            for (int i = 0; i < 16; i++) hist[i] = '0;
        end else if (g >= 0) begin
            if (glock) begin
                m_locked = 1; m_owner = g; m_idle = 0;
            end else begin
                m_locked = 0; m_rr = 1 - g;
            end
        end else if (tfire) begin
            m_locked = 0; m_rr = 1 - m_owner; m_idle = 0;
        end else if (m_locked != 0) begin
            m_idle++;
        end
        #1;
    endtask

    initial begin
        beat_t       rb;
        logic [31:0] abc [3];
        abc[0] = 32'h0000000A; abc[1] = 32'h0000000B; abc[2] = 32'h0000000C;
        for (int i = 0; i < 16; i++) hist[i] = '0;

        @(posedge clk);
        #1;
        $display("[TB] reset state");
        applyStimulus(rdBeat(16'h1234, 1'b0), rdBeat(16'h5678, 1'b0), 32'hFFFFFFFF);
        applyStimulus(idleBeat(), idleBeat(), 32'h0);
        checkOutput("rst_ready0", 32'(s_ready0[0]), 32'd0);
        checkOutput("rst_en", 32'(s_en[0]), 32'd0);

        $display("[TB] single read by req0");
        rst = 1'b0;
        applyStimulus(rdBeat(16'hBFF8, 1'b0), idleBeat(), $urandom);
        checkOutput("t1_ready0", 32'(s_ready0[0]), 32'd1);
        checkOutput("t1_en", 32'(s_en[0]), 32'd1);
        applyStimulus(idleBeat(), idleBeat(), 32'h12345678);
        checkOutput("t1_rsp0_valid", 32'(s_rsp0v[0]), 32'd1);
        checkOutput("t1_rsp0_rdata", s_rsp0d[0], 32'h12345678);
        checkOutput("t1_rsp1_valid", 32'(s_rsp1v[0]), 32'd0);

        $display("[TB] round-robin contention");
        rst = 1'b1;
        applyStimulus(idleBeat(), idleBeat(), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(rdBeat(16'($urandom), 1'b0), rdBeat(16'($urandom), 1'b0), $urandom);
            checkOutput($sformatf("t2_grant0_%0d", i), 32'(s_ready0[0]), 32'(i % 2 == 0));
            checkOutput($sformatf("t2_grant1_%0d", i), 32'(s_ready1[0]), 32'(i % 2 == 1));
            if (i > 0) begin
                checkOutput($sformatf("t2_rsp0_%0d", i), 32'(s_rsp0v[0]), 32'((i - 1) % 2 == 0));
                checkOutput($sformatf("t2_rsp1_%0d", i), 32'(s_rsp1v[0]), 32'((i - 1) % 2 == 1));
            end
        end

        $display("[TB] locked write pair");
        applyStimulus(wrBeat(16'h4000, 4'hF, 32'h11111111, 1'b1), rdBeat(16'h0100, 1'b0), 32'hDEADBEEF);
        checkOutput("t3_ready0_a", 32'(s_ready0[0]), 32'd1);
        checkOutput("t3_ready1_a", 32'(s_ready1[0]), 32'd0);
        applyStimulus(wrBeat(16'h4004, 4'hF, 32'h22222222, 1'b0), rdBeat(16'h0100, 1'b0), 32'hDEADBEEF);
        checkOutput("t3_ready1_b", 32'(s_ready1[0]), 32'd0);
        checkOutput("t3_rsp0_valid_a", 32'(s_rsp0v[0]), 32'd1);
        checkOutput("t3_rsp0_rdata_a", s_rsp0d[0], 32'd0);
        applyStimulus(idleBeat(), rdBeat(16'h0100, 1'b0), 32'hCAFEF00D);
        checkOutput("t3_ready1_c", 32'(s_ready1[0]), 32'd1);
        checkOutput("t3_rsp0_valid_b", 32'(s_rsp0v[0]), 32'd1);
        checkOutput("t3_rsp0_rdata_b", s_rsp0d[0], 32'd0);

        $display("[TB] latency-3 back-to-back reads");
        for (int i = 0; i < 3; i++) applyStimulus(idleBeat(), idleBeat(), $urandom);
        for (int i = 0; i < 3; i++) applyStimulus(idleBeat(), rdBeat(16'(16'h0200 + 4 * i), 1'b0), $urandom);
        checkOutput("t4_rsp1_early", 32'(s_rsp1v[1]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(idleBeat(), idleBeat(), abc[i]);
            checkOutput($sformatf("t4_rsp1_valid_%0d", i), 32'(s_rsp1v[1]), 32'd1);
            checkOutput($sformatf("t4_rsp1_rdata_%0d", i), s_rsp1d[1], abc[i]);
        end

        $display("[TB] reset with reads in flight");
        applyStimulus(rdBeat(16'h0300, 1'b0), idleBeat(), $urandom);
        rst = 1'b1;
        applyStimulus(idleBeat(), idleBeat(), 32'h55555555);
        checkOutput("t5_rsp0_in_reset", 32'(s_rsp0v[0]), 32'd0);
        checkOutput("t5_en_in_reset", 32'(s_en[0]), 32'd0);
        applyStimulus(rdBeat(16'h0304, 1'b0), rdBeat(16'h0308, 1'b0), 32'h66666666);
        rst = 1'b0;
        applyStimulus(rdBeat(16'h0304, 1'b0), rdBeat(16'h0308, 1'b0), 32'h77777777);
        checkOutput("t5_ready0_after", 32'(s_ready0[0]), 32'd1);
        checkOutput("t5_ready1_after", 32'(s_ready1[0]), 32'd0);
        checkOutput("t5_no_stale_rsp", 32'(s_rsp0v[1]), 32'd0);

        $display("[TB] abandoned lock");
        applyStimulus(wrBeat(16'h4008, 4'hF, 32'h33333333, 1'b1), idleBeat(), $urandom);
`ifdef CLINT_ARB_TIMEOUT_EN
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(idleBeat(), rdBeat(16'h0400, 1'b0), $urandom);
            checkOutput($sformatf("t6_timeout_%0d", i), 32'(s_to[0]), 32'(i == 4));
            checkOutput($sformatf("t6_ready1_%0d", i), 32'(s_ready1[0]), 32'(i == 5));
        end
`else
        for (int i = 0; i < 100; i++) begin
            applyStimulus(idleBeat(), rdBeat(16'h0400, 1'b0), $urandom);
            checkOutput($sformatf("t6_held_%0d", i), 32'(s_ready1[0]), 32'd0);
        end
        checkOutput("t6_no_timeout", 32'(s_to[0]), 32'd0);
        applyStimulus(wrBeat(16'h400C, 4'hF, 32'h44444444, 1'b0), rdBeat(16'h0400, 1'b0), $urandom);
        checkOutput("t6_owner_release", 32'(s_ready0[0]), 32'd1);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            rb = rndBeat();
            applyStimulus(rb, rndBeat(), $urandom);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(idleBeat(), idleBeat(), $urandom);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clint_bram_arbiter.md
Name: clint_bram_arbiter

Overview:
Two-requester arbiter that shares the CLINT's single 64KiB, 32-bit BRAM control port between two masters, e.g. the hart-side MMIO bridge (requester 0) and the debug/boot master (requester 1).
- Round-robin grant per beat.
- Lock mechanism so a requester can issue back-to-back beats, e.g. the lo/hi halves of a 64-bit mtime/mtimecmp, without interleaving.
- Returns read data to the issuing requester after the fixed BRAM read latency.

Parameters:
READ_LATENCY, 1, cycles from BRAM issue (bram_en=1) to valid bram_rddata; legal range 1..4.
LOCK_TIMEOUT, 64, idle-cycle limit on a held lock; used only with CLINT_ARB_TIMEOUT_EN; legal range 2..255.

Ports:
clk  in  1  clock for all logic and the BRAM port.
rst  in  1  asynchronous reset, active-high.
req0_valid  in  1  requester 0 beat valid.
req0_ready  out  1  requester 0 beat accepted this cycle when valid&ready.
req0_addr  in  16  byte address.
req0_we  in  4  byte write enables; 0 = read.
req0_wdata  in  32  write data.
req0_lock  in  1  keep grant after this beat.
rsp0_valid  out  1  response pulse for requester 0.
rsp0_rdata  out  32  read data; 0 for writes.
req1_* / rsp1_*  (same set as requester 0, same widths).
bram_addr  out  16  to CLINT BRAM port.
bram_en  out  1  BRAM enable.
bram_we  out  4  BRAM byte write enables.
bram_wrdata  out  32  BRAM write data.
bram_rddata  in  32  BRAM read data, valid READ_LATENCY cycles after issue.
lock_timeout  out  1  one-cycle pulse when a lock is forcibly released.

Behaviour:
- Reset (async, rst=1): rr_ptr=0, lock state UNLOCKED, response pipeline empty. While rst is high, all outputs are 0: both req*_ready, bram_en, rsp*_valid, lock_timeout.
- Issue path is combinational, zero-latency. When a beat is granted, req*_ready=1 and bram_en=1 in the same cycle, with bram_addr/we/wrdata muxed from the winner. With no grant, bram_en=0, bram_we=0, and addr/wrdata are don't-care (drive 0).
- Grant state machine:
  - UNLOCKED, one valid: that requester is granted.
  - UNLOCKED, both valid: requester rr_ptr is granted.
  - After any granted beat with lock=0: rr_ptr = ~winner.
  - Granted beat with lock=1: go to LOCKED(owner=winner); rr_ptr unchanged.
  - LOCKED(n): only requester n can be granted (ready=req_n_valid). The other requester's ready=0 regardless of its valid.
  - LOCKED(n), owner beat with lock=0: return to UNLOCKED, rr_ptr = ~n.
  - LOCKED(n), owner beat with lock=1: stay LOCKED.
- At most one beat issues per cycle. A requester holding valid without ready must keep its inputs stable (AXI-style). This is not checked.
- Response pipeline: a READ_LATENCY-deep shift register of {valid, id, is_read}.
  - Exactly READ_LATENCY cycles after an issue, rsp[id]_valid pulses for one cycle.
  - rsp_rdata = bram_rddata if is_read, else 0.
  - The other requester's rsp_valid is 0 and its rdata is 0.
  - Responses return in issue order. Back-to-back issues give back-to-back responses with no bubbles and no backpressure on responses.
- Simultaneous events: a new grant and a response in the same cycle are independent. A lock release and a new grant to the other requester cannot occur in the same cycle; the other requester's earliest grant is the next cycle.
- Reset mid-operation: in-flight responses are discarded (no rsp pulses after reset) and the lock is cleared.

Optional Feature:
CLINT_ARB_TIMEOUT_EN
- Defined: an 8-bit idle counter runs while LOCKED.
  - Cleared on every owner beat and on entry to LOCKED.
  - Increments each LOCKED cycle with no owner beat.
  - When it reaches LOCK_TIMEOUT: force UNLOCKED, rr_ptr = ~owner, and pulse lock_timeout for 1 cycle. The other requester can be granted the next cycle.
- Not defined: no counter; a lock is held indefinitely; lock_timeout is tied to 0.

Test Plan:
1. Reset, then req0 reads addr 0xBFF8 while the BRAM model returns 0x12345678 -> req0_ready=1 and bram_en=1 in the issue cycle; rsp0_valid with rdata=0x12345678 exactly READ_LATENCY=1 cycle later; rsp1_valid stays 0.
2. Both requesters valid every cycle with lock=0 for 6 cycles -> grants alternate 0,1,0,1,0,1 starting with req0 after reset; responses alternate with 1-cycle lag.
3. req0 writes 0x4000 (we=0xF, lock=1) then 0x4004 (lock=0) while req1 holds valid -> req1_ready=0 for both beats; req1 is granted the cycle after the 0x4004 beat; rsp0 rdata=0 for both writes.
4. READ_LATENCY=3, three back-to-back reads by req1 returning 0xA, 0xB, 0xC -> three consecutive rsp1_valid pulses starting 3 cycles after the first issue, in order A, B, C.
5. Assert rst one cycle after a read issues -> no rsp pulse follows; all outputs read 0 during reset; the first post-reset contention is granted to req0.
6. With CLINT_ARB_TIMEOUT_EN and LOCK_TIMEOUT=4: req0 issues a beat with lock=1 then drops valid, req1 valid -> lock_timeout pulses 4 cycles later; req1 is granted the following cycle. Without the macro, req1 stays ungranted for 100 cycles.
